// File: rtl/gpio_status_tx.sv
// gpio_status_tx: buffers (VAL_0, VAL_1) pairs and returns them to the PS over GP_OUT with a toggle REQ/ACK handshake.
// Define GPIO_STATUS_LEVEL_EN so that a request with GP_IN[29] set reads the FIFO occupancy instead of popping.

module gpio_status_tx #(
  parameter int DAC_WIDTH  = 14,
  parameter int FIFO_DEPTH = 16,
  parameter int GPIO_WIDTH = 32
) (
  input  logic                  ADC_CLK,
  input  logic                  ADC_RST_N,
  input  logic [GPIO_WIDTH-1:0] GP_IN,
  input  logic [DAC_WIDTH-1:0]  VAL_0,
  input  logic [DAC_WIDTH-1:0]  VAL_1,
  input  logic                  VAL_VALID,
  output logic [GPIO_WIDTH-1:0] GP_OUT,
  output logic                  FIFO_FULL,
  output logic                  OVERFLOW
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = 2 * DAC_WIDTH;

  logic [2:0]    sync_1;
  logic [2:0]    sync_2;
  logic          req_d;
  logic [1:0]    settle_cnt;
  logic          req_s;
  logic          clr_s;
  logic          lvl_s;
  logic          settled;
  logic          toggle;
  logic          lvl_query;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_next;
  logic [AW:0]   rd_next;
  logic [AW:0]   occupancy;
  logic          fifo_empty;
  logic          fifo_full_now;
  logic          full_next;
  logic          do_pop;
  logic          do_push;
  logic          drop;
  logic [PW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic          ack;
  logic          valid;
  logic          seq;
  logic          ovf;
  logic [27:0]   data;
  logic          unused_bits;

  assign req_s = sync_2[2];
  assign clr_s = sync_2[1];
  assign lvl_s = sync_2[0];

  // A REQ level present at reset release must not look like a toggle.
  assign settled = (settle_cnt == 2'd3);
  assign toggle  = settled & (req_s ^ req_d);

`ifdef GPIO_STATUS_LEVEL_EN
  assign lvl_query   = toggle & lvl_s;
  assign occupancy   = wr_ptr - rd_ptr;
  assign unused_bits = ^GP_IN[28:0];
`else
  assign lvl_query   = 1'b0;
  assign occupancy   = '0;
  assign unused_bits = ^{GP_IN[28:0], lvl_s};
`endif

  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign fifo_full_now = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head          = mem[rd_ptr[AW-1:0]];

  // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
  assign do_pop  = toggle & ~lvl_query & ~clr_s & ~fifo_empty;
  assign do_push = VAL_VALID & ~clr_s & (~fifo_full_now | do_pop);
  assign drop    = VAL_VALID & ~clr_s & fifo_full_now & ~do_pop;

  assign wr_next   = clr_s ? '0 : wr_ptr + (AW+1)'(do_push);
  assign rd_next   = clr_s ? '0 : rd_ptr + (AW+1)'(do_pop);
  assign full_next = (wr_next[AW] != rd_next[AW]) && (wr_next[AW-1:0] == rd_next[AW-1:0]);

  always_ff @(posedge ADC_CLK or negedge ADC_RST_N) begin
    if (!ADC_RST_N) begin
      sync_1     <= '0;
      sync_2     <= '0;
      req_d      <= 1'b0;
      settle_cnt <= '0;
    end else begin
      sync_1 <= GP_IN[31:29];
      sync_2 <= sync_1;
      req_d  <= req_s;
      if (!settled) settle_cnt <= settle_cnt + 2'd1;
    end
  end

  always_ff @(posedge ADC_CLK or negedge ADC_RST_N) begin
    if (!ADC_RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      FIFO_FULL <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      wr_ptr    <= wr_next;
      rd_ptr    <= rd_next;
      FIFO_FULL <= full_next;
      if (clr_s) ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge ADC_CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= {VAL_1, VAL_0};
  end

  // The response word only moves on a request or while CLR is asserted.
  always_ff @(posedge ADC_CLK or negedge ADC_RST_N) begin
    if (!ADC_RST_N) begin
      ack   <= 1'b0;
      valid <= 1'b0;
      seq   <= 1'b0;
      data  <= '0;
    end else if (toggle) begin
      ack <= req_s;
      if (lvl_query) begin
        valid <= 1'b0;
        data  <= 28'(occupancy);
      end else if (do_pop) begin
        valid <= 1'b1;
        seq   <= ~seq;
        data  <= {14'(head[PW-1:DAC_WIDTH]), 14'(head[DAC_WIDTH-1:0])};
      end else begin
        valid <= 1'b0;
        data  <= '0;
      end
    end else if (clr_s) begin
      valid <= 1'b0;
    end
  end

  assign GP_OUT   = {ack, valid, ovf, seq, data};
  assign OVERFLOW = ovf;

endmodule
